// File: rtl/ads1115_channel_scheduler.sv
// ADS1115 single-shot scan scheduler: config write, conversion wait, result read per masked channel.
// Define ADS_POLL_OS_EN to replace the fixed conversion wait with OS-bit polling of the config register.
module ads1115_channel_scheduler #(
    parameter logic [2:0]  PGA              = 3'b001,
    parameter logic [2:0]  DR               = 3'b100,
    parameter int unsigned CONV_WAIT_CYCLES = 450000,
    parameter int unsigned SCAN_GAP_CYCLES  = 5000000,
    parameter int unsigned MAX_RETRIES      = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [3:0]  channel_mask,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic        cmd_write,
    output logic [1:0]  cmd_ptr,
    output logic [15:0] cmd_wdata,
    input  logic        rsp_valid,
    input  logic        rsp_nack,
    input  logic [15:0] rsp_rdata,
    output logic        result_valid,
    output logic [15:0] result_data,
    output logic [1:0]  result_ch,
    output logic        scan_done,
    output logic        err_valid,
    output logic [1:0]  err_ch,
    output logic        busy
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_CFG,
        S_WR_RSP,
        S_CONV_WAIT,
        S_POLL_REQ,
        S_POLL_RSP,
        S_POLL_WAIT,
        S_RD_REQ,
        S_RD_RSP,
        S_RETRY,
        S_NEXT,
        S_GAP
    } state_t;

`ifdef ADS_POLL_OS_EN
    localparam int unsigned POLL_INTERVAL = 1000;
`endif

    state_t      state_q, state_d;
    logic [1:0]  ch_q, ch_d;
    logic [3:0]  mask_q, mask_d;
    logic [31:0] retry_q, retry_d;
    logic [31:0] cnt_q, cnt_d;
`ifdef ADS_POLL_OS_EN
    logic [31:0] tot_q, tot_d;
`endif
    logic        result_valid_q, result_valid_d;
    logic [15:0] result_data_q, result_data_d;
    logic [1:0]  result_ch_q, result_ch_d;
    logic        err_valid_q, err_valid_d;
    logic [1:0]  err_ch_q, err_ch_d;
    logic        scan_done_q, scan_done_d;
    logic [2:0]  first_ch;
    logic [2:0]  next_ch;

    // Returns {found, channel}: lowest set bit of m at or above index from.
    function automatic logic [2:0] find_ch(input logic [3:0] m, input int unsigned from);
        logic [2:0] r;
        r = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (!r[2] && i >= from && m[i[1:0]]) begin
                r = {1'b1, i[1:0]};
            end
        end
        return r;
    endfunction

    function automatic logic [15:0] cfg_word(input logic [1:0] ch);
        return {1'b1, 1'b1, ch, PGA, 1'b1, DR, 5'b00011};
    endfunction

    assign first_ch = find_ch(channel_mask, 0);
    assign next_ch  = find_ch(mask_q, {30'd0, ch_q} + 32'd1);

    always_comb begin
        state_d        = state_q;
        ch_d           = ch_q;
        mask_d         = mask_q;
        retry_d        = retry_q;
        cnt_d          = cnt_q;
`ifdef ADS_POLL_OS_EN
        tot_d          = tot_q;
`endif
        result_valid_d = 1'b0;
        result_data_d  = result_data_q;
        result_ch_d    = result_ch_q;
        err_valid_d    = 1'b0;
        err_ch_d       = err_ch_q;
        scan_done_d    = 1'b0;
        cmd_valid      = 1'b0;
        cmd_write      = 1'b0;
        cmd_ptr        = 2'b00;
        cmd_wdata      = '0;

        case (state_q)
            S_IDLE: begin
                if (enable && channel_mask != 4'b0000) begin
                    mask_d  = channel_mask;
                    ch_d    = first_ch[1:0];
                    state_d = S_WR_CFG;
                end
            end
            S_WR_CFG: begin
                cmd_valid = 1'b1;
                cmd_write = 1'b1;
                cmd_ptr   = 2'b01;
                cmd_wdata = cfg_word(ch_q);
                if (cmd_ready) state_d = S_WR_RSP;
            end
            S_WR_RSP: begin
                if (rsp_valid) begin
                    if (rsp_nack) begin
                        state_d = S_RETRY;
                    end else begin
                        cnt_d   = '0;
`ifdef ADS_POLL_OS_EN
                        tot_d   = '0;
                        state_d = S_POLL_REQ;
`else
                        state_d = S_CONV_WAIT;
`endif
                    end
                end
            end
`ifdef ADS_POLL_OS_EN
            // The conversion timeout runs across all poll states from the config ack.
            S_POLL_REQ: begin
                tot_d     = tot_q + 32'd1;
                cmd_valid = 1'b1;
                cmd_ptr   = 2'b01;
                if (cmd_ready) state_d = S_POLL_RSP;
            end
            S_POLL_RSP: begin
                tot_d = tot_q + 32'd1;
                if (rsp_valid) begin
                    if (rsp_nack) begin
                        state_d = S_RETRY;
                    end else if (rsp_rdata[15]) begin
                        state_d = S_RD_REQ;
                    end else if (tot_q >= CONV_WAIT_CYCLES) begin
                        state_d = S_RETRY;
                    end else begin
                        cnt_d   = '0;
                        state_d = S_POLL_WAIT;
                    end
                end
            end
            S_POLL_WAIT: begin
                tot_d = tot_q + 32'd1;
                cnt_d = cnt_q + 32'd1;
                if (tot_q >= CONV_WAIT_CYCLES) begin
                    state_d = S_RETRY;
                end else if (cnt_q == POLL_INTERVAL - 1) begin
                    state_d = S_POLL_REQ;
                end
            end
`else
            S_CONV_WAIT: begin
                cnt_d = cnt_q + 32'd1;
                if (cnt_q == CONV_WAIT_CYCLES - 1) begin
                    cnt_d   = '0;
                    state_d = S_RD_REQ;
                end
            end
`endif
            S_RD_REQ: begin
                cmd_valid = 1'b1;
                cmd_ptr   = 2'b00;
                if (cmd_ready) state_d = S_RD_RSP;
            end
            S_RD_RSP: begin
                if (rsp_valid) begin
                    if (rsp_nack) begin
                        state_d = S_RETRY;
                    end else begin
                        result_valid_d = 1'b1;
                        result_data_d  = rsp_rdata;
                        result_ch_d    = ch_q;
                        retry_d        = '0;
                        state_d        = S_NEXT;
                    end
                end
            end
            S_RETRY: begin
                if (retry_q + 32'd1 >= MAX_RETRIES) begin
                    err_valid_d = 1'b1;
                    err_ch_d    = ch_q;
                    retry_d     = '0;
                    state_d     = S_NEXT;
                end else begin
                    retry_d = retry_q + 32'd1;
                    state_d = S_WR_CFG;
                end
            end
            S_NEXT: begin
                if (next_ch[2]) begin
                    ch_d    = next_ch[1:0];
                    state_d = S_WR_CFG;
                end else begin
                    scan_done_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = S_GAP;
                end
            end
            S_GAP: begin
                cnt_d = cnt_q + 32'd1;
                if (cnt_q == SCAN_GAP_CYCLES - 1) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            ch_q           <= '0;
            mask_q         <= '0;
            retry_q        <= '0;
            cnt_q          <= '0;
`ifdef ADS_POLL_OS_EN
            tot_q          <= '0;
`endif
            result_valid_q <= 1'b0;
            result_data_q  <= '0;
            result_ch_q    <= '0;
            err_valid_q    <= 1'b0;
            err_ch_q       <= '0;
            scan_done_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            ch_q           <= ch_d;
            mask_q         <= mask_d;
            retry_q        <= retry_d;
            cnt_q          <= cnt_d;
`ifdef ADS_POLL_OS_EN
            tot_q          <= tot_d;
`endif
            result_valid_q <= result_valid_d;
            result_data_q  <= result_data_d;
            result_ch_q    <= result_ch_d;
            err_valid_q    <= err_valid_d;
            err_ch_q       <= err_ch_d;
            scan_done_q    <= scan_done_d;
        end
    end

    assign result_valid = result_valid_q;
    assign result_data  = result_data_q;
    assign result_ch    = result_ch_q;
    assign err_valid    = err_valid_q;
    assign err_ch       = err_ch_q;
    assign scan_done    = scan_done_q;
    assign busy         = (state_q != S_IDLE) && (state_q != S_GAP);

endmodule

// File: doc/ads1115_channel_scheduler.md
Name: ads1115_channel_scheduler

Overview:
Sequences single-shot conversions on the ADS1115 across up to four single-ended inputs (AIN0..AIN3 vs GND). Drives a one-outstanding-transaction command/response port of the I2C transaction engine: config write, conversion wait, conversion-register read. Publishes each 16-bit result tagged with its channel, for the LCD/display path.

Parameters:
PGA, 3'b001, ADS1115 PGA field (±4.096 V)
DR, 3'b100, ADS1115 data-rate field (128 SPS)
CONV_WAIT_CYCLES, 450000, clk cycles from config-write ack to conversion read (9 ms at 50 MHz)
SCAN_GAP_CYCLES, 5000000, idle clk cycles between scans (100 ms at 50 MHz)
MAX_RETRIES, 3, NACKed attempts per channel before it is skipped

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  run scans while high
channel_mask  in  4  bit n = scan AINn; sampled at start of each scan
cmd_valid  out  1  transaction request to I2C engine
cmd_ready  in  1  engine accepts request when high with cmd_valid
cmd_write  out  1  1 = write register, 0 = read register
cmd_ptr  out  2  ADS1115 pointer (00 conversion, 01 config)
cmd_wdata  out  16  write payload
rsp_valid  in  1  one-cycle transaction completion
rsp_nack  in  1  qualifies rsp_valid: transaction NACKed
rsp_rdata  in  16  read data, valid with rsp_valid
result_valid  out  1  one-cycle pulse, new result
result_data  out  16  signed conversion code
result_ch  out  2  channel of result_data
scan_done  out  1  one-cycle pulse after last masked channel handled
err_valid  out  1  one-cycle pulse, channel skipped after MAX_RETRIES NACKs
err_ch  out  2  channel of err_valid
busy  out  1  high in any state except IDLE/GAP

Behaviour:
- Reset (synchronous, wins over all): state IDLE; all outputs 0; retry count 0; latched mask 0; counters 0. Reset mid-transaction drops cmd_valid on the next edge, no pending response honoured.
- Config word = {1'b1 OS, 1'b1, ch[1:0], PGA, 1'b1 single-shot, DR, 5'b00011 comparator off}. For ch=0, PGA=001, DR=100: 16'hC383.
- IDLE: if enable && channel_mask!=0, latch mask, ch = lowest set bit, -> WR_CFG. Otherwise stay.
- WR_CFG: cmd_valid=1, cmd_write=1, cmd_ptr=01, cmd_wdata=config. Payload stable until the cmd_valid&&cmd_ready cycle; cmd_valid is low the cycle after acceptance. -> WR_RSP.
- WR_RSP: on rsp_valid, ok -> CONV_WAIT (counter loaded); nack -> RETRY.
- CONV_WAIT: count CONV_WAIT_CYCLES cycles, then -> RD_REQ.
- RD_REQ: cmd_write=0, cmd_ptr=00, cmd_wdata=0; handshake as WR_CFG. -> RD_RSP.
- RD_RSP: on rsp_valid, ok: result_data<=rsp_rdata, result_ch<=ch, result_valid pulses next cycle, retry count cleared, -> NEXT. Nack -> RETRY.
- RETRY: retry count+1. If it reaches MAX_RETRIES: err_valid/err_ch pulse, count cleared, -> NEXT. Otherwise -> WR_CFG, same channel (full restart).
- NEXT: ch = next set bit of latched mask above ch. If none: scan_done pulse, -> GAP.
- GAP: count SCAN_GAP_CYCLES, then -> IDLE. Mask is re-sampled in IDLE.
- enable low: no effect on an in-progress scan; the scan completes. Blocks only the IDLE -> WR_CFG start.
- channel_mask changes mid-scan: ignored until the next scan.
- rsp_valid outside WR_RSP/RD_RSP: ignored.
- Results are never coalesced: each read produces exactly one result_valid.
- Worst-case latency per channel = handshake + CONV_WAIT_CYCLES + engine transaction time.

Optional Feature:
ADS_POLL_OS_EN:
- Defined: CONV_WAIT is replaced by POLL. POLL issues a config-register read (cmd_ptr=01), every 1000 cycles after each response.
  - rsp_rdata[15]=1: -> RD_REQ.
  - nack: -> RETRY.
  - After CONV_WAIT_CYCLES total with OS still 0: treated as a nack (-> RETRY).
- Undefined: fixed CONV_WAIT delay only; no polling reads are issued.

Test Plan:
- Mask 4'b0101, enable=1, engine always ready/acks, reads return 16'h1234 then 16'h8001. Required: config writes C383 then E383; result_valid (ch0,1234), then (ch2,8001); then scan_done; next scan starts ≥SCAN_GAP_CYCLES later.
- cmd_ready held low 20 cycles during WR_CFG. Required: cmd_valid/cmd_ptr/cmd_wdata stable all 20 cycles; exactly one write issued.
- Mask 4'b0010, config write NACKed 3 times. Required: 3 write attempts; err_valid with err_ch=1; no result_valid; scan_done.
- Read NACKed once then succeeds with 16'h7FFF. Required: the config write is reissued; result_valid (ch1,7FFF); the next channel starts with retry count 0.
- Reset asserted while in RD_RSP. Required: next cycle all outputs 0, busy=0. A subsequent rsp_valid is ignored, no result emitted.
- ADS_POLL_OS_EN defined, polls return OS=0 twice then 16'h8583. Required: 3 polling reads (ptr 01), then a ptr 00 read, then the result published.
